// File: rtl/adam_mem_to_axil.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adam_mem_to_axil                                                           |
// | Bridges the adam_mem request/grant protocol to a single-outstanding        |
// | AXI-Lite initiator. Optional watchdog: ADAM_MEM_TO_AXIL_TIMEOUT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adam_mem_to_axil #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  mem_req,
  output logic                  mem_gnt,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_we,
  input  logic [STRB_WIDTH-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,

  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [2:0]            aw_prot,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [2:0]            ar_prot,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RRESP = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_addr_mask = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_aw_pend;
  logic                  r_w_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [STRB_WIDTH-1:0] r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_grant;
  logic                  w_wr_done;
  logic                  w_rd_done;
  logic                  w_timeout;
  logic                  w_unused;

  // Grant is gated by rstn so nothing is accepted while reset is held.
  assign w_grant   = (r_state == S_IDLE) && mem_req && rstn;
  assign w_wr_done = (r_state == S_WRESP) && b_valid && !w_timeout;
  assign w_rd_done = (r_state == S_RRESP) && r_valid && !w_timeout;
  assign w_unused  = b_resp[0] ^ r_resp[0];

`ifdef ADAM_MEM_TO_AXIL_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Counter reads 0 in the first cycle after grant, so the limit fires in
  // the TIMEOUT_CYCLES-th busy cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
  localparam logic [31:0] c_timeout_unused = 32'(TIMEOUT_CYCLES);

  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = mem_we ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        // Either channel may already be done; a handshake this cycle counts too.
        if ((!r_aw_pend || aw_ready) && (!r_w_pend || w_ready)) begin
          w_state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        if (b_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RADDR: begin
        if (ar_ready) begin
          w_state_nxt = S_RRESP;
        end
      end
      S_RRESP: begin
        if (r_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else if (w_grant) begin
      r_aw_pend <= mem_we;
      r_w_pend  <= mem_we;
    end else if (w_timeout) begin
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else begin
      if (aw_ready) begin
        r_aw_pend <= 1'b0;
      end
      if (w_ready) begin
        r_w_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_addr  <= mem_addr;
      r_be    <= mem_be;
      r_wdata <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_wr_done || w_rd_done || w_timeout;
      if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (w_wr_done) begin
        r_rdata <= '0;
        r_err   <= b_resp[1];
      end else if (w_rd_done) begin
        r_rdata <= r_data;
        r_err   <= r_resp[1];
      end
    end
  end

  assign mem_gnt    = w_grant;
  assign mem_rvalid = r_rvalid;
  assign mem_rdata  = r_rdata;
  assign mem_err    = r_err;

  assign aw_addr  = r_addr & c_addr_mask;
  assign aw_prot  = 3'b000;
  assign aw_valid = r_aw_pend;
  assign w_data   = r_wdata;
  assign w_strb   = r_be;
  assign w_valid  = r_w_pend;
  assign b_ready  = (r_state == S_WRESP);
  assign ar_addr  = r_addr & c_addr_mask;
  assign ar_prot  = 3'b000;
  assign ar_valid = (r_state == S_RADDR);
  assign r_ready  = (r_state == S_RRESP);

endmodule
`default_nettype wire

// File: tb/tb_adam_mem_to_axil.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adam_mem_to_axil                                                        |
// | Randomised bench with reference memory and response scoreboard.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_adam_mem_to_axil;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          mem_req = 1'b0, mem_gnt, mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [SW-1:0] mem_be = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_rvalid, mem_err;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [2:0]    aw_prot, ar_prot;
  logic          aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic          aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [DW-1:0] w_data, r_data;
  logic [SW-1:0] w_strb;
  logic [1:0]    b_resp, r_resp;

  always #5 clk = ~clk;

  adam_mem_to_axil #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rv = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int gcyc; bit exact; } exp_t;
  typedef struct { logic we; logic [31:0] addr; } aexp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } wexp_t;
  exp_t  exp_q[$];
  aexp_t aq[$];
  wexp_t wq[$];

  // rmem: request-level reference; smem: what the AXI slave actually stores.
  logic [31:0] rmem [4096];
  logic [31:0] smem [4096];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[b*8 +: 8] = nw[b*8 +: 8];
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- AXI-Lite slave ----------------
  bit rnd = 0, stall_ar = 0, stall_r = 0, chk_hold = 1;
  int w_delay = 0;
  bit have_aw = 0, have_w = 0, b_pend = 0, r_pend = 0;
  int b_wait = 0, r_wait = 0, since_aw = 0;
  int cnt_awv = 0, cnt_wv = 0, cnt_bhs = 0;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0, last_awaddr = '0;
  logic [3:0]  s_wstrb = '0;
  bit p_aw = 0, p_w = 0, p_ar = 0;
  logic [31:0] p_awaddr = '0, p_araddr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  initial begin
    aexp_t a;
    wexp_t w;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; since_aw = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (chk_hold && p_aw) check("aw_stable", 64'({aw_valid, aw_addr}), 64'({1'b1, p_awaddr}));
        if (chk_hold && p_w)  check("w_stable", 64'({w_valid, w_strb, w_data}), 64'({1'b1, p_wstrb, p_wdata}));
        if (chk_hold && p_ar) check("ar_stable", 64'({ar_valid, ar_addr}), 64'({1'b1, p_araddr}));
        if (aw_valid) cnt_awv++;
        if (w_valid) cnt_wv++;
        if (aw_valid && aw_ready) begin
          if (aq.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
          else begin
            a = aq.pop_front();
            check("aw_kind", 64'(a.we), 64'(1));
            check("aw_addr", 64'(aw_addr), 64'(a.addr));
            check("aw_prot", 64'(aw_prot), 64'(0));
          end
          have_aw = 1; s_awaddr = aw_addr; last_awaddr = aw_addr; since_aw = 0;
        end
        if (have_aw) since_aw++;
        if (w_valid && w_ready) begin
          if (wq.size() == 0) check("w_unexpected", 64'(1), 64'(0));
          else begin
            w = wq.pop_front();
            check("w_data", 64'(w_data), 64'(w.data));
            check("w_strb", 64'(w_strb), 64'(w.strb));
          end
          have_w = 1; s_wdata = w_data; s_wstrb = w_strb;
        end
        if (b_valid && b_ready) begin b_pend = 0; cnt_bhs++; end
        if (have_aw && have_w) begin
          smem[s_awaddr[13:2]] = merge(smem[s_awaddr[13:2]], s_wdata, s_wstrb);
          b_pend = 1; b_wait = rnd ? int'($urandom % 3) : 0;
          have_aw = 0; have_w = 0; since_aw = 0;
        end
        if (r_valid && r_ready) r_pend = 0;
        if (ar_valid && ar_ready) begin
          if (aq.size() == 0) check("ar_unexpected", 64'(1), 64'(0));
          else begin
            a = aq.pop_front();
            check("ar_kind", 64'(a.we), 64'(0));
            check("ar_addr", 64'(ar_addr), 64'(a.addr));
            check("ar_prot", 64'(ar_prot), 64'(0));
          end
          r_pend = 1; r_wait = rnd ? int'($urandom % 3) : 0; s_araddr = ar_addr;
        end
        p_aw = aw_valid && !aw_ready; p_awaddr = aw_addr;
        p_w  = w_valid && !w_ready;   p_wdata = w_data; p_wstrb = w_strb;
        p_ar = ar_valid && !ar_ready; p_araddr = ar_addr;
      end
      @(posedge clk); #1;
      aw_ready = rnd ? 1'($urandom % 2) : 1'b1;
      w_ready  = rnd ? 1'($urandom % 2) : ((w_delay == 0) || (since_aw >= w_delay));
      ar_ready = stall_ar ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
      if (!b_pend) b_valid = 0;
      else if (b_wait == 0) begin b_valid = 1; b_resp = s_awaddr[13] ? 2'b10 : 2'b00; end
      else b_wait--;
      if (!r_pend || stall_r) r_valid = 0;
      else if (r_wait == 0) begin
        r_valid = 1; r_data = smem[s_araddr[13:2]]; r_resp = s_araddr[13] ? 2'b10 : 2'b00;
      end else r_wait--;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    bit prev_rv;
    logic [31:0] hd;
    logic he;
    exp_t e;
    prev_rv = 0; hd = '0; he = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_rv = 0; hd = '0; he = 0;
      end else begin
        if (mem_rvalid) begin
          n_rv++;
          check("rvalid_pulse", 64'(prev_rv), 64'(0));
          if (exp_q.size() == 0) check("rvalid_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            check("mem_rdata", 64'(mem_rdata), 64'(e.rdata));
            check("mem_err", 64'(mem_err), 64'(e.err));
            if (e.exact) check("latency", 64'(cyc - e.gcyc), 64'(3));
            else check("latency_min", 64'((cyc - e.gcyc) >= 3), 64'(1));
          end
          hd = mem_rdata; he = mem_err;
        end else begin
          check("rdata_hold", 64'({mem_err, mem_rdata}), 64'({he, hd}));
        end
        prev_rv = mem_rvalid;
      end
    end
  end

  // ---------------- requester and reference model ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input bit exact, input bit keep,
                       output int gcyc, output logic rv_at_gnt);
    exp_t e; aexp_t a; wexp_t w; int n;
    mem_req = 1; mem_we = we; mem_addr = addr; mem_be = be; mem_wdata = wd;
    n = 0; gcyc = -1; rv_at_gnt = 0;
    while (1) begin
      @(negedge clk);
      if (mem_gnt) break;
      n++;
      if (n > 2000) break;
    end
    if (!mem_gnt) begin
      check("grant_timeout", 64'(0), 64'(1));
    end else begin
      gcyc = cyc; rv_at_gnt = mem_rvalid;
      e.err = addr[13]; e.exact = exact; e.gcyc = cyc;
      if (we) begin
        e.rdata = '0;
        rmem[addr[13:2]] = merge(rmem[addr[13:2]], wd, be);
        w.data = wd; w.strb = be; wq.push_back(w);
      end else begin
        e.rdata = rmem[addr[13:2]];
      end
      a.we = we; a.addr = addr & 32'hFFFF_FFFC;
      aq.push_back(a); exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) mem_req = 0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin @(posedge clk); #1; n++; end
    check("drain_outstanding", 64'(exp_q.size()), 64'(0));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    rstn = 0; mem_req = 1;
    repeat (n) begin
      @(negedge clk);
      check("gnt_in_reset", 64'(mem_gnt), 64'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("reset_outputs", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready, mem_rvalid, mem_err}), 64'(0));
    check("reset_rdata", 64'(mem_rdata), 64'(0));
    mem_req = 0;
    exp_q.delete(); aq.delete(); wq.delete();
    @(posedge clk); #1;
    rstn = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench hung");
  end

  initial begin
    int g1, g2, cnt, rv0;
    logic rvg;
    logic        we;
    logic [31:0] addr;
    for (int i = 0; i < 4096; i++) begin
      rmem[i] = i * 32'h9E37_79B1;
      smem[i] = rmem[i];
    end
    rmem[12'h800] = 32'h1234_5678;
    smem[12'h800] = 32'h1234_5678;

    do_reset(2);
    repeat (2) begin @(posedge clk); #1; end

    // Zero-wait write with unaligned address, then SLVERR read.
    issue(1, 32'h0000_1003, 4'hF, 32'hDEAD_BEEF, 1, 0, g1, rvg);
    drain(50);
    check("t023_aw_addr", 64'(last_awaddr), 64'(32'h1000));
    check("t023_err", 64'(mem_err), 64'(0));
    issue(0, 32'h0000_2000, 4'hF, 32'h0, 1, 0, g1, rvg);
    drain(50);
    check("t024_rdata", 64'(mem_rdata), 64'(32'h1234_5678));
    check("t024_err", 64'(mem_err), 64'(1));
    issue(0, 32'h0000_1000, 4'h0, 32'h0, 1, 0, g1, rvg);
    drain(50);

    // Write with no byte enables must leave memory untouched.
    issue(1, 32'h0000_1004, 4'h0, 32'hFFFF_FFFF, 1, 0, g1, rvg);
    issue(0, 32'h0000_1004, 4'hF, 32'h0, 0, 0, g1, rvg);
    drain(50);

    // W channel held off four cycles after AW.
    w_delay = 4; cnt_awv = 0; cnt_wv = 0; cnt_bhs = 0; rv0 = n_rv;
    issue(1, 32'h0000_0040, 4'h5, 32'hA5A5_5A5A, 0, 0, g1, rvg);
    drain(50);
    check("t025_aw_cycles", 64'(cnt_awv), 64'(1));
    check("t025_w_cycles", 64'(cnt_wv), 64'(5));
    check("t025_b_count", 64'(cnt_bhs), 64'(1));
    check("t025_rvalid_count", 64'(n_rv - rv0), 64'(1));
    w_delay = 0;

    // Back-to-back reads with mem_req held.
    issue(0, 32'h0000_0040, 4'hF, 32'h0, 1, 1, g1, rvg);
    issue(0, 32'h0000_2000, 4'hF, 32'h0, 1, 0, g2, rvg);
    check("t026_grant_gap", 64'(g2 - g1), 64'(3));
    check("t026_rvalid_at_grant", 64'(rvg), 64'(1));
    drain(50);

    // Reset while waiting in the read-response state.
    stall_r = 1; rv0 = n_rv;
    issue(0, 32'h0000_3000, 4'hF, 32'h0, 0, 0, g1, rvg);
    cnt = 0;
    while (!r_ready && cnt < 20) begin @(negedge clk); cnt++; end
    check("t027_reached_rresp", 64'(r_ready), 64'(1));
    @(posedge clk); #1;
    do_reset(1);
    stall_r = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("t027_no_rvalid", 64'(n_rv - rv0), 64'(0));
    issue(0, 32'h0000_2000, 4'hF, 32'h0, 1, 0, g1, rvg);
    drain(50);

    // AR never accepted.
    stall_ar = 1;
    issue(0, 32'h0000_5000, 4'hF, 32'h0, 0, 0, g1, rvg);
`ifdef ADAM_MEM_TO_AXIL_TIMEOUT_EN
    chk_hold = 0;
    exp_q[exp_q.size() - 1].rdata = '0;
    exp_q[exp_q.size() - 1].err = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ar_valid) cnt++;
    end
    check("t028_ar_cycles", 64'(cnt), 64'(TO));
    drain(50);
    aq.delete();
    chk_hold = 1;
    stall_ar = 0;
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ar_valid) cnt++;
    end
    check("t028_ar_held", 64'(cnt), 64'(1000));
    @(posedge clk); #1;
    stall_ar = 0;
    drain(50);
`endif

    // Randomised traffic over a small address pool with random slave timing.
    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      we   = 1'($urandom % 2);
      addr = ($urandom & 32'hFFFF_E000) | (($urandom % 16) << 2) | ($urandom % 4);
      issue(we, addr, 4'($urandom % 16), $urandom, 0, (i != 399) && ($urandom % 2 == 1), g1, rvg);
      if (!mem_req) repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
    mem_req = 0;
    drain(300);
    rnd = 0;
    repeat (4) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
